// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared CPU package for the register-file write path.
// Holds the register/data widths, the register-$0 constant, the write-request
// struct used by the writeback stage and the write-port arbiter, and a helper
// that tells whether a destination register actually holds state.
package regfile_wb_arbiter_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;
    localparam int NREG   = 1 << REG_W;

    // Register $0 is hard-wired to zero; writes to it are dropped.
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic              wr;
        logic [REG_W-1:0]  addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    // True when a destination register holds state (anything but $0).
    function automatic logic is_live_reg(input logic [REG_W-1:0] addr);
        return (addr != REG_ZERO);
    endfunction

endpackage

// File: rtl/wb_fifo2.sv
// wb_fifo2: two-entry FIFO buffering multi-cycle results ({addr, data}).
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   push, push_addr/data enqueue an entry (ignored when full)
//   pop                  dequeue the head (ignored when empty)
//   head_addr/head_data  current head entry (valid when count != 0)
//   count                number of buffered entries, 0..2
module wb_fifo2
    import regfile_wb_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [REG_W-1:0]  push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [REG_W-1:0]  head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic [1:0]        count
);

    logic [REG_W-1:0]  addr_r [2];
    logic [DATA_W-1:0] data_r [2];
    logic              wr_ptr_r;
    logic              rd_ptr_r;
    logic [1:0]        count_r;
    logic              push_ok_s;
    logic              pop_ok_s;

    assign push_ok_s = push & (count_r != 2'd2);
    assign pop_ok_s  = pop & (count_r != 2'd0);

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_r[0] <= REG_ZERO;
            addr_r[1] <= REG_ZERO;
            data_r[0] <= {DATA_W{1'b0}};
            data_r[1] <= {DATA_W{1'b0}};
            wr_ptr_r  <= 1'b0;
            rd_ptr_r  <= 1'b0;
            count_r   <= 2'd0;
        end else begin
            if (push_ok_s) begin
                addr_r[wr_ptr_r] <= push_addr;
                data_r[wr_ptr_r] <= push_data;
                wr_ptr_r         <= ~wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_addr = addr_r[rd_ptr_r];
    assign head_data = data_r[rd_ptr_r];
    assign count     = count_r;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file's single write port between
// the pipeline writeback stage (always wins) and buffered multi-cycle results,
// tracks registers with an outstanding multi-cycle result (busy scoreboard),
// and forces the pipeline to hold when a buffered result starves.
// Ports:
//   clk, reset                     clock, asynchronous active-low reset
//   wb_wr/wb_addr/wb_data          writeback request (granted same cycle)
//   mc_valid/mc_addr/mc_data       multi-cycle result; mc_ready = FIFO has room
//   iss_valid/iss_addr             multi-cycle issue, marks destination busy
//   chk_addr1/chk_addr2, stall     decode source hazard check
//   pipe_hold                      registered request to keep wb_wr low
//   err                            sticky: issue to an already-busy register
//   rf_wr/rf_addr/rf_data          register file write port
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_wr,
    input  logic [REG_W-1:0]  wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              mc_valid,
    input  logic [REG_W-1:0]  mc_addr,
    input  logic [DATA_W-1:0] mc_data,
    output logic              mc_ready,
    input  logic              iss_valid,
    input  logic [REG_W-1:0]  iss_addr,
    input  logic [REG_W-1:0]  chk_addr1,
    input  logic [REG_W-1:0]  chk_addr2,
    output logic              stall,
    output logic              pipe_hold,
    output logic              err,
    output logic              rf_wr,
    output logic [REG_W-1:0]  rf_addr,
    output logic [DATA_W-1:0] rf_data
);

    localparam logic [3:0] STARVE_LAST = 4'(STARVE_MAX - 1);

    logic [1:0]        fifo_count_s;
    logic [REG_W-1:0]  head_addr_s;
    logic [DATA_W-1:0] head_data_s;
    logic              fifo_empty_s;
    logic              wb_take_s;
    logic              push_s;
    logic              pop_s;
    logic              blocked_s;
    wr_req_t           mux_req_s;

    logic [NREG-1:0]   busy_r;
    logic [NREG-1:0]   busy_nxt_s;
    logic              err_r;
    logic              err_set_s;
    logic [3:0]        starve_r;
    logic [3:0]        starve_nxt_s;
    logic              hold_r;
    logic              hold_nxt_s;

    assign fifo_empty_s = (fifo_count_s == 2'd0);
    assign wb_take_s    = wb_wr & is_live_reg(wb_addr);
    // mc_ready is a function of reset and the registered count only.
    assign mc_ready     = reset & (fifo_count_s != 2'd2);
    // Results for $0 are accepted but never stored.
    assign push_s       = mc_valid & mc_ready & is_live_reg(mc_addr);
    assign pop_s        = reset & ~wb_take_s & ~fifo_empty_s;
    assign blocked_s    = ~fifo_empty_s & wb_take_s;

    wb_fifo2 u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_addr (mc_addr),
        .push_data (mc_data),
        .pop       (pop_s),
        .head_addr (head_addr_s),
        .head_data (head_data_s),
        .count     (fifo_count_s)
    );

    // Write-port mux: live writeback first, then the FIFO head, else idle.
    always_comb begin
        mux_req_s = {1'b0, REG_ZERO, {DATA_W{1'b0}}};
        if (!reset) begin
            mux_req_s = {1'b0, REG_ZERO, {DATA_W{1'b0}}};
        end else if (wb_take_s) begin
            mux_req_s = {1'b1, wb_addr, wb_data};
        end else if (!fifo_empty_s) begin
            mux_req_s = {1'b1, head_addr_s, head_data_s};
        end else begin
            mux_req_s = {1'b0, REG_ZERO, {DATA_W{1'b0}}};
        end
    end

    assign rf_wr   = mux_req_s.wr;
    assign rf_addr = mux_req_s.addr;
    assign rf_data = mux_req_s.data;

    // Scoreboard next state: drain clears, issue sets afterwards so set wins.
    always_comb begin
        busy_nxt_s = busy_r;
        err_set_s  = 1'b0;
        if (pop_s) begin
            busy_nxt_s[head_addr_s] = 1'b0;
        end else begin
            busy_nxt_s = busy_r;
        end
        if (iss_valid && is_live_reg(iss_addr)) begin
            busy_nxt_s[iss_addr] = 1'b1;
            err_set_s            = busy_r[iss_addr];
        end else begin
            err_set_s = 1'b0;
        end
        busy_nxt_s[0] = 1'b0;
    end

    // Starvation: count cycles the head loses the port, request a hold.
    always_comb begin
        starve_nxt_s = starve_r;
        hold_nxt_s   = hold_r;
        if (fifo_empty_s || pop_s) begin
            starve_nxt_s = 4'd0;
        end else if (starve_r != 4'd15) begin
            starve_nxt_s = starve_r + 4'd1;
        end else begin
            starve_nxt_s = starve_r;
        end
        if (pop_s) begin
            hold_nxt_s = 1'b0;
        end else if (blocked_s && (starve_r == STARVE_LAST)) begin
            hold_nxt_s = 1'b1;
        end else begin
            hold_nxt_s = hold_r;
        end
    end

    // Scoreboard, sticky error and starvation state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r   <= {NREG{1'b0}};
            err_r    <= 1'b0;
            starve_r <= 4'd0;
            hold_r   <= 1'b0;
        end else begin
            busy_r   <= busy_nxt_s;
            err_r    <= err_r | err_set_s;
            starve_r <= starve_nxt_s;
            hold_r   <= hold_nxt_s;
        end
    end

    assign stall = (is_live_reg(chk_addr1) & busy_r[chk_addr1]) |
                   (is_live_reg(chk_addr2) & busy_r[chk_addr2]);
    assign pipe_hold = hold_r;
    assign err       = err_r;

endmodule
